// File: rtl/sar_sequencer_if.sv
// sar_sequencer_if: SAR handshake, control and result-stream signals of sar_sequencer
interface sar_sequencer_if #(parameter int AW = 3);
  logic enable, eoc, start, dout_valid, dout_ready, overflow, timeout_err, clr_flags;
  logic [7:0] data_in, dout;
  logic [AW:0] level;
  modport master (
    output enable, eoc, data_in, dout_ready, clr_flags,
    input start, dout, dout_valid, level, overflow, timeout_err
  );
  modport slave (
    input enable, eoc, data_in, dout_ready, clr_flags,
    output start, dout, dout_valid, level, overflow, timeout_err
  );
endinterface

// File: rtl/sar_sequencer.sv
// sar_sequencer: periodic SAR start pulses, eoc capture into an FWFT FIFO, sticky drop/timeout flags
module sar_sequencer #(
  parameter int PERIOD = 40,
  parameter int DEPTH = 8,
  parameter int AW = 3,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic reset,
  sar_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, START, CONVERT, WAIT} state_t;
  state_t state, state_nx;
  logic [7:0] pcnt, tcnt;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] level;
  logic capture, timed_out, push, pop;
  always_comb begin
    state_nx = state;
    capture = 1'b0;
    timed_out = 1'b0;
    case (state)
      IDLE: state_nx = bus.enable ? START : IDLE;
      START: state_nx = CONVERT;
      CONVERT: begin
        capture = bus.eoc;
        timed_out = !bus.eoc && tcnt == 8'(TIMEOUT - 1);
        state_nx = (capture || timed_out) ? WAIT : CONVERT;
      end
      default: state_nx = pcnt == 8'(PERIOD - 1) ? (bus.enable ? START : IDLE) : WAIT;
    endcase
  end
  assign pop = bus.dout_valid && bus.dout_ready;
  assign push = capture && (level != (AW+1)'(DEPTH) || pop);
  assign bus.start = state == START;
  assign bus.dout = mem[rd_ptr];
  assign bus.dout_valid = level != '0;
  assign bus.level = level;
  // The period counter wraps, so a conversion outlasting PERIOD restarts on the next PERIOD boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pcnt <= '0;
      tcnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      bus.overflow <= 1'b0;
      bus.timeout_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_nx;
      pcnt <= (state_nx == START || pcnt == 8'(PERIOD - 1)) ? '0 : pcnt + 8'd1;
      tcnt <= state_nx == START ? '0 : tcnt + 8'd1;
      if (push) mem[wr_ptr] <= bus.data_in;
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
      bus.overflow <= (capture && !push) || (bus.overflow && !bus.clr_flags);
      bus.timeout_err <= timed_out || (bus.timeout_err && !bus.clr_flags);
    end
  end
endmodule

// File: tb/tb_sar_sequencer.sv
// tb_sar_sequencer: randomized SAR/consumer stimulus checked every cycle against an age-based event model
module tb_sar_sequencer;
  localparam int P = 40, D = 8, TO = 64;
  logic clk = 1'b0, reset = 1'b0;
  sar_sequencer_if #(.AW(3)) bus();
  sar_sequencer #(.PERIOD(P), .DEPTH(D), .AW(3), .TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int tests = 0, fails = 0, cyc = 0;
  bit m_idle = 1, m_conv = 0, m_ovf = 0, m_tmo = 0;
  int m_age = 0, m_next = 0, m_caps = 0;
  logic [7:0] q[$], drained[$], data_tab[$], exp_q[$];
  int sar_lat = 34, ready_mode = 0, clr_pct = 0, tmo_rise = -1, en_cyc = 0;
  bit en_knob = 0, extra_eoc = 0, clr_force = 0;
  int start_log[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.enable = 0; bus.eoc = 0; bus.data_in = 0; bus.dout_ready = 0; bus.clr_flags = 0;
    @(posedge clk);
    m_idle = 1; m_conv = 0; m_age = 0; m_next = 0; m_ovf = 0; m_tmo = 0;
    q.delete(); start_log.delete(); tmo_rise = -1;
    #1 reset = 1'b0;
  endtask

  // One cycle: compare outputs, drive inputs, advance the model to the next cycle.
  task automatic step();
    logic cap, to, pop, push;
    @(negedge clk);
    cyc++;
    chk("start", bus.start, 32'(!m_idle && m_age == 0));
    chk("level", bus.level, q.size());
    chk("dout_valid", bus.dout_valid, 32'(q.size() != 0));
    if (q.size() != 0) chk("dout", bus.dout, q[0]);
    chk("overflow", bus.overflow, m_ovf);
    chk("timeout_err", bus.timeout_err, m_tmo);
    if (bus.start) start_log.push_back(cyc);
    if (bus.timeout_err && tmo_rise < 0) tmo_rise = cyc;
    bus.enable = en_knob;
    bus.eoc = 0;
    bus.data_in = 8'($urandom);
    if (!m_idle && m_conv && sar_lat > 0 && m_age == sar_lat) begin
      bus.eoc = 1;
      if (data_tab.size() != 0) bus.data_in = data_tab.pop_front();
    end else if (extra_eoc && !m_conv && $urandom_range(0, 2) == 0) begin
      bus.eoc = 1;
      bus.data_in = 8'h77;
    end
    bus.dout_ready = ready_mode == 1 ? 1'b1 : ready_mode == 2 ? 1'($urandom_range(0, 1)) :
                     ready_mode == 3 ? (bus.eoc && m_conv) : 1'b0;
    bus.clr_flags = clr_force || $urandom_range(0, 99) < clr_pct;
    cap = 0;
    to = 0;
    if (!m_idle && m_conv && m_age >= 1) begin
      if (bus.eoc) cap = 1;
      else if (m_age == TO - 1) to = 1;
      if (cap || to) begin
        m_conv = 0;
        m_next = ((m_age + 2 + P - 1) / P) * P;
      end
    end
    if (cap) m_caps++;
    pop = q.size() != 0 && bus.dout_ready;
    push = cap && (q.size() < D || pop);
    if (pop) begin
      drained.push_back(bus.dout);
      void'(q.pop_front());
    end
    if (push) q.push_back(bus.data_in);
    m_ovf = (cap && !push) || (m_ovf && !bus.clr_flags);
    m_tmo = to || (m_tmo && !bus.clr_flags);
    if (m_idle) begin
      if (bus.enable) begin m_idle = 0; m_age = 0; m_conv = 1; end
    end else if (!m_conv && m_age + 1 == m_next) begin
      if (bus.enable) begin m_age = 0; m_conv = 1; end
      else m_idle = 1;
    end else m_age++;
    @(posedge clk);
  endtask

  task automatic drain(int n);
    drained.delete();
    ready_mode = 1;
    repeat (n) step();
    ready_mode = 0;
  endtask

  task automatic chk_drain(string name);
    chk({name, "_count"}, drained.size(), exp_q.size());
    foreach (exp_q[i]) if (i < drained.size()) chk(name, drained[i], exp_q[i]);
  endtask

  task automatic clear_flags();
    clr_force = 1;
    step();
    clr_force = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.enable = 0; bus.eoc = 0; bus.data_in = 0; bus.dout_ready = 0; bus.clr_flags = 0;
    do_reset();
    chk("rst_dout", bus.dout, 0);
    chk("rst_level", bus.level, 0);
    chk("rst_valid", bus.dout_valid, 0);
    chk("rst_start", bus.start, 0);
    chk("rst_flags", {bus.overflow, bus.timeout_err}, 0);
    // basic sequence with three known samples
    data_tab = '{8'hA5, 8'h3C, 8'hFF};
    m_caps = 0;
    step(); step();
    en_knob = 1;
    en_cyc = cyc + 1;
    for (int i = 0; i < 300 && m_caps < 3; i++) step();
    en_knob = 0;
    step();
    chk("t1_level", bus.level, 3);
    chk("t1_first_start", start_log.size() > 0 ? start_log[0] : -1, en_cyc + 1);
    chk("t1_spacing", start_log.size() >= 3 ? start_log[2] - start_log[0] : -1, 80);
    drain(6);
    exp_q = '{8'hA5, 8'h3C, 8'hFF};
    chk_drain("t1_drain");
    // overflow with nine samples and no consumer
    repeat (50) step();
    m_caps = 0;
    data_tab.delete();
    for (int i = 1; i <= 9; i++) data_tab.push_back(8'(i));
    sar_lat = 20;
    en_knob = 1;
    for (int i = 0; i < 600 && m_caps < 9; i++) step();
    en_knob = 0;
    step();
    chk("t2_level", bus.level, 8);
    chk("t2_overflow", bus.overflow, 1);
    drain(12);
    exp_q.delete();
    for (int i = 1; i <= 8; i++) exp_q.push_back(8'(i));
    chk_drain("t2_drain");
    clear_flags();
    step();
    chk("t2_clr", bus.overflow, 0);
    // full FIFO, push coinciding with pop
    repeat (50) step();
    m_caps = 0;
    data_tab.delete();
    for (int i = 11; i <= 19; i++) data_tab.push_back(8'(i));
    en_knob = 1;
    for (int i = 0; i < 600 && m_caps < 8; i++) step();
    ready_mode = 3;
    for (int i = 0; i < 100 && m_caps < 9; i++) step();
    en_knob = 0;
    ready_mode = 0;
    step();
    chk("t3_level", bus.level, 8);
    chk("t3_overflow", bus.overflow, 0);
    drain(12);
    exp_q.delete();
    for (int i = 12; i <= 19; i++) exp_q.push_back(8'(i));
    chk_drain("t3_drain");
    // SAR never answers
    repeat (50) step();
    clear_flags();
    start_log.delete();
    tmo_rise = -1;
    sar_lat = 0;
    en_knob = 1;
    for (int i = 0; i < 300 && start_log.size() < 2; i++) step();
    en_knob = 0;
    chk("t4_tmo_delay", start_log.size() > 0 && tmo_rise >= 0 ? tmo_rise - start_log[0] : -1, 64);
    chk("t4_restart_grid", start_log.size() >= 2 ? start_log[1] - start_log[0] : -1, 80);
    chk("t4_level", bus.level, 0);
    repeat (90) step();
    clear_flags();
    // stray eoc pulses outside CONVERT
    m_caps = 0;
    start_log.delete();
    data_tab = '{8'd10, 8'd20, 8'd30};
    sar_lat = 25;
    extra_eoc = 1;
    en_knob = 1;
    for (int i = 0; i < 300 && m_caps < 3; i++) step();
    en_knob = 0;
    repeat (60) step();
    chk("t5_level", bus.level, 3);
    chk("t5_starts", start_log.size(), 3);
    extra_eoc = 0;
    drain(6);
    exp_q = '{8'd10, 8'd20, 8'd30};
    chk_drain("t5_drain");
    // reset in the middle of a conversion
    repeat (50) step();
    m_caps = 0;
    sar_lat = 30;
    en_knob = 1;
    for (int i = 0; i < 300 && m_caps < 3; i++) step();
    for (int i = 0; i < 100 && !(m_conv && m_age == 10); i++) step();
    en_knob = 0;
    do_reset();
    chk("t6_level", bus.level, 0);
    chk("t6_valid", bus.dout_valid, 0);
    chk("t6_start", bus.start, 0);
    repeat (5) step();
    chk("t6_no_start", start_log.size(), 0);
    en_knob = 1;
    step(); step();
    chk("t6_restart", start_log.size(), 1);
    en_knob = 0;
    repeat (50) step();
    // randomized traffic
    for (int b = 0; b < 60; b++) begin
      sar_lat = $urandom_range(1, 70);
      ready_mode = 2;
      extra_eoc = 1'($urandom_range(0, 1));
      en_knob = $urandom_range(0, 3) != 0;
      clr_pct = 3;
      if ($urandom_range(0, 19) == 0) do_reset();
      for (int i = 0; i < 50; i++) step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
